// File: rtl/mem_access_unit.sv
// mem_access_unit -- memory-stage load/store responder.
//
// Takes one load or store per instruction from the EX/MEM register. The ALU
// byte address is turned into a memory word address, and a req/ack handshake
// runs with the data memory. freeze stays high until the access completes.
// Illegal requests return at once with an err pulse. Accesses with no ack
// abort after TIMEOUT cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   mem_r_en   load request
//   mem_w_en   store request
//   alu_res    byte address
//   st_val     store data
//   freeze     stall the pipeline while an access is outstanding
//   rd_data    load result
//   rd_valid   one-cycle pulse, rd_data valid for the current load
//   err        one-cycle pulse: illegal address, both enables, or timeout
//   mem_req    memory request
//   mem_we     1 = write, 0 = read; valid while mem_req is high
//   mem_addr   word address
//   mem_wdata  write data
//   mem_ack    memory completion, only honoured while mem_req is high
//   mem_rdata  read data, valid with mem_ack
module mem_access_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     st_val,
  output logic                  freeze,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int unsigned         CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0]   BASE      = DATA_W'(BASE_ADDR);
  // The counter starts at 0 in the first REQ cycle, so the last allowed wait
  // cycle is the one where it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0]    LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              timed_out_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] word_idx;
  logic              addr_ok;
  logic              any_en;
  logic              both_en;
  logic              accept;
  logic              reject;
  logic              expire;

  // Address decode and request classification
  always_comb begin
    offset   = alu_res - BASE;
    word_idx = offset >> 2;
    // Any word-index bit above MEM_ADDR_W means the address is past the end
    // of the memory.
    addr_ok  = (alu_res >= BASE) && (alu_res[1:0] == 2'b00) &&
               ((word_idx >> MEM_ADDR_W) == '0);
    any_en   = mem_r_en | mem_w_en;
    both_en  = mem_r_en & mem_w_en;
    accept   = (state_q == IDLE) && any_en && !both_en && addr_ok;
    reject   = (state_q == IDLE) && any_en && (both_en || !addr_ok);
    expire   = (state_q == REQ) && !mem_ack && (cnt_q == LAST_WAIT);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    freeze   = 1'b0;
    rd_valid = 1'b0;
    err      = 1'b0;
    mem_req  = 1'b0;
    rd_data  = rd_data_q;
    // While reset is held the combinational outputs are forced low as well.
    // This keeps freeze low even if the enables are still asserted.
    if (rst) begin
      case (state_q)
        IDLE: begin
          freeze   = accept;
          err      = reject;
          rd_valid = reject & mem_r_en;
          if (reject) rd_data = '0;
        end
        REQ: begin
          freeze  = 1'b1;
          mem_req = 1'b1;
        end
        DONE: begin
          rd_valid = !mem_we;
          err      = timed_out_q;
        end
        default: ;
      endcase
    end
  end

  // Access registers: address/data latched on accept, load data and timeout
  // status captured when the handshake ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mem_addr    <= word_idx[MEM_ADDR_W-1:0];
            mem_wdata   <= st_val;
            mem_we      <= mem_w_en;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
          end else if (reject) begin
            rd_data_q <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) rd_data_q <= mem_rdata;
          end else if (expire) begin
            timed_out_q <= 1'b1;
            rd_data_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed bench for mem_access_unit.
// A bench-side memory acks after a programmed number of wait cycles. Each
// instruction pushes its expected outcome onto a scoreboard queue. The entry
// is popped and compared when the instruction leaves the stage, which is the
// first cycle with freeze low.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, st_val;
  logic        freeze;
  logic [31:0] rd_data;
  logic        rd_valid, err;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit #(
    .DATA_W(32), .MEM_ADDR_W(16), .BASE_ADDR(1024), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .st_val(st_val),
    .freeze(freeze), .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_valid;
    logic        err;
    logic [31:0] rd_data;
    int          freeze_cycles;
    int          req_cycles;
    int          acks;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd  = '0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles with no enables. ack lets a stray mem_ack be driven.
  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      mem_r_en  = 1'b0;
      mem_w_en  = 1'b0;
      mem_ack   = ack;
      mem_rdata = $urandom;
      #1;
      chk("idle", {mem_req, freeze, rd_valid, err, rd_data}, {4'b0000, last_rd});
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  // One instruction. wait_c = wait cycles before ack (-1 = never).
  // Called at a falling edge and returns at a falling edge.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int wait_c, input logic [31:0] rdata);
    exp_t        e, got;
    logic        legal, acked, done;
    logic [31:0] widx;
    logic [15:0] exp_addr;
    int          nreq, nack, nfrz, cyc;

    widx     = (addr - 32'd1024) >> 2;
    exp_addr = widx[15:0];
    legal    = (r ^ w) && (addr >= 32'd1024) && (addr[1:0] == 2'b00) &&
               (widx < 32'd65536);
    acked    = legal && (wait_c >= 0) && (wait_c < TIMEOUT);
    e.rd_valid      = r;
    e.err           = !acked;
    e.rd_data       = acked ? (r ? rdata : last_rd) : 32'd0;
    e.req_cycles    = !legal ? 0 : (acked ? wait_c + 1 : TIMEOUT);
    e.freeze_cycles = legal ? e.req_cycles + 1 : 0;
    e.acks          = acked ? 1 : 0;
    sb.push_back(e);
    last_rd = e.rd_data;

    mem_r_en = r;
    mem_w_en = w;
    alu_res  = addr;
    st_val   = wdata;
    nreq = 0; nack = 0; nfrz = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      mem_ack   = mem_req && (wait_c >= 0) && (nreq == wait_c);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
      if (mem_req) begin
        chk({tag, ".req_fields"}, {mem_we, mem_addr, mem_wdata}, {w, exp_addr, wdata});
        nreq++;
        if (mem_ack) nack++;
      end
      if (freeze) begin
        nfrz++;
        chk({tag, ".no_early_result"}, {rd_valid, err}, 2'b00);
      end else begin
        done = 1'b1;
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL %s.sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk({tag, ".rd_valid"}, rd_valid, got.rd_valid);
          chk({tag, ".err"},      err,      got.err);
          chk({tag, ".rd_data"},  rd_data,  got.rd_data);
          chk({tag, ".freeze_cycles"}, nfrz, got.freeze_cycles);
          chk({tag, ".req_cycles"},    nreq, got.req_cycles);
          chk({tag, ".acks"},          nack, got.acks);
          chk({tag, ".done_no_req"},   mem_req, 1'b0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL %s.bound observed=%0d expected=<64", tag, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; st_val = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("reset_state", {freeze, rd_valid, err, mem_req, mem_we, mem_addr, mem_wdata, rd_data},
        {5'b0, 16'h0, 32'h0, 32'h0});
    @(negedge clk);
    rst = 1'b1;
    idle(1, 1'b0);

    // Basic load, ack in the first REQ cycle
    access("load1032", 1'b1, 1'b0, 32'd1032, 32'h0, 0, 32'hDEADBEEF);
    idle(1, 1'b0);
    // Store with 4 wait cycles
    access("store1024", 1'b0, 1'b1, 32'd1024, 32'h12345678, 4, 32'h0);
    idle(1, 1'b0);
    // Illegal: misaligned load, then below-base store
    access("ld_misalign", 1'b1, 1'b0, 32'd1026, 32'h0, 0, 32'h0);
    access("st_below",    1'b0, 1'b1, 32'd1000, 32'hAAAA5555, 0, 32'h0);
    idle(1, 1'b0);
    // Timeout, then late acks must be ignored
    access("ld_timeout", 1'b1, 1'b0, 32'd2048, 32'h0, -1, 32'h0);
    idle(3, 1'b1);
    // Back-to-back load then store
    access("b2b_load",  1'b1, 1'b0, 32'd1036, 32'h0, 0, 32'hCAFEF00D);
    access("b2b_store", 1'b0, 1'b1, 32'd1040, 32'h0BADBEEF, 0, 32'h0);
    idle(1, 1'b0);
    // Ack in the last allowed cycle versus one cycle too late
    access("ack_last", 1'b1, 1'b0, 32'd1100, 32'h0, TIMEOUT - 1, 32'h13572468);
    access("ack_late", 1'b0, 1'b1, 32'd1104, 32'h55AA55AA, TIMEOUT, 32'h0);
    idle(1, 1'b0);
    // Both enables, top word, one past the top word
    access("both_en",  1'b1, 1'b1, 32'd1032, 32'h0, 0, 32'h0);
    access("top_word", 1'b1, 1'b0, 32'd263164, 32'h0, 2, 32'h89ABCDEF);
    access("past_top", 1'b0, 1'b1, 32'd263168, 32'h1, 0, 32'h0);
    idle(1, 1'b0);

    // Reset in the middle of a REQ
    mem_r_en = 1'b1; mem_w_en = 1'b0; alu_res = 32'd1040;
    #1;
    chk("rst_mid.freeze_idle", freeze, 1'b1);
    @(negedge clk);
    #1;
    chk("rst_mid.req_up", mem_req, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.abort", {mem_req, freeze, rd_valid, err, mem_addr}, {4'b0000, 16'h0});
    @(negedge clk);
    mem_r_en = 1'b0;
    rst = 1'b1;
    last_rd = '0;
    #1;
    chk("rst_mid.idle_after", {mem_req, freeze}, 2'b00);
    @(negedge clk);
    access("after_rst", 1'b1, 1'b0, 32'd1044, 32'h0, 1, 32'h2468ACE0);
    idle(2, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
